cv32e40p_x_result_fifo: RTL



---
 rtl/cv32e40p_x_result_fifo.sv | 110 +++++++++++
 1 files changed

// File: rtl/cv32e40p_x_result_fifo.sv
// Registered result FIFO between the coprocessor result outputs and the core result inputs.
// Results stay in order, and no combinational path runs from m_ready_i to s_ready_o.
module cv32e40p_x_result_fifo #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ID_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      s_valid_i,
  output logic                      s_ready_o,
  input  logic [ID_WIDTH-1:0]       s_id_i,
  input  logic [31:0]               s_data_i,
  input  logic [4:0]                s_rd_i,
  input  logic                      s_we_i,
  input  logic                      s_float_i,
  input  logic                      s_exc_i,
  input  logic [5:0]                s_exccode_i,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic [ID_WIDTH-1:0]       m_id_o,
  output logic [31:0]               m_data_o,
  output logic [4:0]                m_rd_o,
  output logic                      m_we_o,
  output logic                      m_float_o,
  output logic                      m_exc_o,
  output logic [5:0]                m_exccode_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [31:0]         data;
    logic [4:0]          rd;
    logic                we;
    logic                fp;
    logic                exc;
    logic [5:0]          exccode;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             s_entry;
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               push;
  logic               pop;

  assign s_entry = '{id: s_id_i, data: s_data_i, rd: s_rd_i, we: s_we_i,
                     fp: s_float_i, exc: s_exc_i, exccode: s_exccode_i};

  // Both handshakes depend only on registered occupancy, plus flush on the input side.
  assign s_ready_o = (count_q != FULL_CNT) & ~flush_i;
  assign m_valid_o = (count_q != '0);
  assign push      = s_valid_i & s_ready_o;
  assign pop       = m_valid_o & m_ready_i;

  assign head        = mem[rd_ptr];
  assign m_id_o      = head.id;
  assign m_data_o    = head.data;
  assign m_rd_o      = head.rd;
  assign m_we_o      = head.we;
  assign m_float_o   = head.fp;
  assign m_exc_o     = head.exc;
  assign m_exccode_o = head.exccode;
  assign count_o     = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= s_entry;
    end
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (count_q == FULL_CNT) |-> !push);
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (count_q == '0) |-> !pop);
  a_head_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (m_valid_o && !m_ready_i && !flush_i) |=> (m_valid_o && $stable(head)));
  a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= FULL_CNT);

endmodule
